// File: rtl/div_fu_if.sv
// -----------------------------------------------------------------------------
// div_fu_if
// Handshake bundle between the divide reservation table / CDB arbiter and the
// iterative divider functional unit.
//
//   master : issuing side (reservation table + CDB arbiter)
//   slave  : divider functional unit
//
// Signals
//   start       issue strobe (start_calculate)
//   div_type    0=DIV, 1=DIVU, 2=REM, 3=REMU
//   rs1_v/rs2_v dividend / divisor, valid with start
//   rob_id_in   ROB tag of issued op
//   rd_in       physical destination of issued op
//   flush       squash in-flight op
//   cdb_ack     CDB arbiter accepted current result
//   ready       unit idle, may accept start next edge (FU_Ready)
//   cdb_valid   result valid on CDB outputs
//   cdb_rob_id  tag of result
//   cdb_rd      destination of result
//   cdb_value   quotient or remainder
// -----------------------------------------------------------------------------
interface div_fu_if #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 3,
  parameter int PREG_W   = 6
);
  logic                start;
  logic [1:0]          div_type;
  logic [XLEN-1:0]     rs1_v;
  logic [XLEN-1:0]     rs2_v;
  logic [ROB_ID_W-1:0] rob_id_in;
  logic [PREG_W-1:0]   rd_in;
  logic                flush;
  logic                cdb_ack;
  logic                ready;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [PREG_W-1:0]   cdb_rd;
  logic [XLEN-1:0]     cdb_value;

  modport master (
    output start, div_type, rs1_v, rs2_v, rob_id_in, rd_in, flush, cdb_ack,
    input  ready, cdb_valid, cdb_rob_id, cdb_rd, cdb_value
  );

  modport slave (
    input  start, div_type, rs1_v, rs2_v, rob_id_in, rd_in, flush, cdb_ack,
    output ready, cdb_valid, cdb_rob_id, cdb_rd, cdb_value
  );
endinterface

// File: rtl/div_fu_iterative.sv
// -----------------------------------------------------------------------------
// div_fu_iterative
// Iterative radix-2 (restoring) integer divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; the result is held on the CDB outputs until the
// arbiter acknowledges it.
//
// Ports
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  div_fu_if.slave (issue inputs, flush, cdb_ack, ready, CDB outputs)
//
// Optional feature
//   DIV_EARLY_OUT_EN : when defined, a non-special op with |dividend| <
//   |divisor| skips the iterative phase (quotient 0, remainder |dividend|).
// -----------------------------------------------------------------------------
module div_fu_iterative #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 3,
  parameter int PREG_W   = 6
) (
  input logic    clk,
  input logic    rst,
  div_fu_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state;
  logic [1:0]      op_type;
  logic            sign_q;     // quotient must be negated in FIXUP
  logic            sign_r;     // remainder must be negated in FIXUP
  logic [XLEN:0]   rem_q;      // partial remainder, one guard bit
  logic [XLEN-1:0] quo_q;      // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] dvsr_q;     // divisor magnitude
  logic [CNT_W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Issue-side decode (only meaningful in IDLE with start)
  // ---------------------------------------------------------------------------
  logic            in_signed;
  logic            in_rem;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_by_zero;
  logic            sgn_overflow;
  logic [XLEN-1:0] special_val;

  assign in_signed    = ~bus.div_type[0];
  assign in_rem       = bus.div_type[1];
  assign abs_a        = (in_signed && bus.rs1_v[XLEN-1]) ? -bus.rs1_v : bus.rs1_v;
  assign abs_b        = (in_signed && bus.rs2_v[XLEN-1]) ? -bus.rs2_v : bus.rs2_v;
  assign div_by_zero  = (bus.rs2_v == '0);
  assign sgn_overflow = in_signed
                        && (bus.rs1_v == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.rs2_v == '1);

  // RISC-V defined results: x/0 = all ones, x%0 = x; MIN/-1 = MIN, MIN%-1 = 0.
  assign special_val = div_by_zero  ? (in_rem ? bus.rs1_v : '1)
                                    : (in_rem ? '0 : bus.rs1_v);

  // ---------------------------------------------------------------------------
  // Restoring step: shift in next dividend bit, subtract if it fits.
  // The guard bit of the trial difference is its borrow (sign).
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            take;

  assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign take    = ~trial[XLEN];

  // Sign correction applied once, after the unsigned iteration.
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign q_fix = sign_q ? -quo_q : quo_q;
  assign r_fix = sign_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  assign bus.ready = (state == IDLE);

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only a priority branch inside the
    // clocked block, not part of the sensitivity list.
    if (rst) begin
      state          <= IDLE;
      op_type        <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvsr_q         <= '0;
      cnt            <= '0;
      bus.cdb_valid  <= 1'b0;
      bus.cdb_rob_id <= '0;
      bus.cdb_rd     <= '0;
      bus.cdb_value  <= '0;
    end else if (bus.flush) begin
      // Squash wins over start and ack; stale tag is never presented valid.
      state         <= IDLE;
      bus.cdb_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_type        <= bus.div_type;
            bus.cdb_rob_id <= bus.rob_id_in;
            bus.cdb_rd     <= bus.rd_in;
            sign_q         <= in_signed & (bus.rs1_v[XLEN-1] ^ bus.rs2_v[XLEN-1]);
            sign_r         <= in_signed & bus.rs1_v[XLEN-1];
            if (div_by_zero || sgn_overflow) begin
              bus.cdb_value <= special_val;
              bus.cdb_valid <= 1'b1;
              state         <= DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (abs_a < abs_b) begin
              quo_q <= '0;
              rem_q <= {1'b0, abs_a};
              state <= FIXUP;
            end
`endif
            else begin
              quo_q  <= abs_a;
              rem_q  <= '0;
              dvsr_q <= abs_b;
              cnt    <= CNT_W'(XLEN - 1);
              state  <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= take ? trial : shifted;
          quo_q <= {quo_q[XLEN-2:0], take};
          if (cnt == '0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        FIXUP: begin
          bus.cdb_value <= op_type[1] ? r_fix : q_fix;
          bus.cdb_valid <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          if (bus.cdb_ack) begin
            bus.cdb_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
